// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for a 16-bit accumulator machine.
// Owns PC/IR/MBR/AC and drives a sync-read main memory port plus an external ALU.
module cpu_control_sequencer #(
  parameter int                ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ac,
  output logic [15:0]       ir,
  output logic              halted,
  output logic              illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_READ,
    S_RWAIT,
    S_EXEC,
    S_WRITE,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ALUM  = 4'h3;
  localparam logic [3:0] OP_JUMP  = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_LOADI = 4'h6;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [15:0]         ir_reg, ir_next;
  logic [15:0]         ac_reg, ac_next;
  logic [15:0]         mbr_reg, mbr_next;
  logic                mem_we_raw;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   a12_addr;
  logic [15:0]         pc_ext;
  logic [15:0]         a12_ext;

  assign opcode = ir_reg[15:12];

  // a12 is zero-extended or truncated to the PC width, so JUMP targets wrap.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_a12
      if (gi < 12) begin : g_bit
        assign a12_addr[gi] = ir_reg[gi];
      end else begin : g_zero
        assign a12_addr[gi] = 1'b0;
      end
    end

    for (gi = 0; gi < 16; gi++) begin : g_ext
      if (gi < ADDR_W) begin : g_bit
        assign pc_ext[gi]  = pc_reg[gi];
        assign a12_ext[gi] = a12_addr[gi];
      end else begin : g_zero
        assign pc_ext[gi]  = 1'b0;
        assign a12_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      ac_reg    <= '0;
      mbr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      ac_reg    <= ac_next;
      mbr_reg   <= mbr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    ac_next    = ac_reg;
    mbr_next   = mbr_reg;
    mem_addr   = pc_ext;
    mem_we_raw = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_FWAIT;
      end
      S_FWAIT: begin
        ir_next    = mem_rdata;
        pc_next    = pc_reg + ADDR_W'(1);
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_FETCH;
        case (opcode)
          OP_HALT:  state_next = S_HALTED;
          OP_LOAD:  state_next = S_READ;
          OP_ALUM:  state_next = S_READ;
          OP_STORE: state_next = S_WRITE;
          OP_JUMP:  pc_next = a12_addr;
          OP_JZ: begin
            if (ac_reg == 16'h0000) pc_next = a12_addr;
          end
          OP_LOADI: ac_next = {4'b0000, ir_reg[11:0]};
          default:  illegal_op = 1'b1;
        endcase
      end
      S_READ: begin
        mem_addr   = (opcode == OP_LOAD) ? a12_ext : {8'h00, ir_reg[7:0]};
        state_next = S_RWAIT;
      end
      S_RWAIT: begin
        mbr_next   = mem_rdata;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        ac_next    = (opcode == OP_LOAD) ? mbr_reg : alu_result;
        state_next = S_FETCH;
      end
      S_WRITE: begin
        mem_addr   = a12_ext;
        mem_we_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Gating with reset keeps a store from landing on the reset edge.
  assign mem_we     = mem_we_raw & ~reset;
  assign mem_wdata  = ac_reg;
  assign alu_opcode = ir_reg[11:8];
  assign alu_a      = ac_reg;
  assign alu_b      = mbr_reg;
  assign pc         = pc_reg;
  assign ac         = ac_reg;
  assign ir         = ir_reg;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: program table plus hand-written
// sequences for reset-during-store, PC wrap, jump, illegal opcode and resume.
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [13:0] pc;
  logic [15:0] ac, ir;
  logic        halted, illegal_op;

  // second instance, reset PC at the top of memory, used for the wrap check
  logic        reset2 = 1'b1;
  logic        start2 = 1'b0;
  logic [15:0] mem_addr2, mem_wdata2, mem_rdata2;
  logic        mem_we2;
  logic [3:0]  alu_opcode2;
  logic [15:0] alu_a2, alu_b2;
  logic [15:0] alu_result2 = 16'h0000;
  logic [13:0] pc2;
  logic [15:0] ac2, ir2;
  logic        halted2, illegal_op2;

  logic        ld_we = 1'b0;
  logic [13:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] mem [0:16383];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_control_sequencer #(.ADDR_W(14), .RESET_PC(14'h0000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc(pc), .ac(ac), .ir(ir), .halted(halted), .illegal_op(illegal_op)
  );

  cpu_control_sequencer #(.ADDR_W(14), .RESET_PC(14'h3FFF)) dut_wrap (
    .clk(clk), .reset(reset2), .start(start2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2),
    .alu_opcode(alu_opcode2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_result(alu_result2),
    .pc(pc2), .ac(ac2), .ir(ir2), .halted(halted2), .illegal_op(illegal_op2)
  );

  // Main memory: sync read, one-cycle latency; the wrap instance only reads.
  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
    mem_rdata  <= mem[mem_addr[13:0]];
    mem_rdata2 <= mem[mem_addr2[13:0]];
  end

  // Reference ALU
  always_comb begin
    alu_result = 16'h0000;
    case (alu_opcode)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h2: alu_result = alu_a & alu_b;
      4'h3: alu_result = alu_a | alu_b;
      4'h4: alu_result = alu_a ^ alu_b;
      4'hE: alu_result = (alu_a > alu_b) ? 16'h0001 : 16'h0000;
      default: alu_result = 16'h0000;
    endcase
  end

  typedef struct {
    logic [63:0] prog;      // word k lives at [16k +: 16]
    logic [15:0] daddr;
    logic [15:0] dval;
    int          exp_cycles;
    logic [15:0] exp_ac;
    logic [13:0] exp_pc;
    logic [15:0] chk_addr;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [13:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    tick();
    ld_we   = 1'b0;
  endtask

  // Holds reset for one edge, then releases it with start high for one edge.
  task automatic launch();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_halted(output int cycles);
    cycles = 0;
    while (!halted && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int first_at, second_at, n_high;
    logic [13:0] pc_at_pulse;
    logic [15:0] ac_at_pulse;
    bit seen;

    vecs[0] = '{64'h0000_1010_2010_6123, 16'h0010, 16'hDEAD, 16, 16'h0123, 14'h0004, 16'h0010, 16'h0123};
    vecs[1] = '{64'h0000_0000_3020_6007, 16'h0020, 16'h0005, 12, 16'h000C, 14'h0003, 16'h0020, 16'h0005};
    vecs[2] = '{64'h0000_0000_3E20_6007, 16'h0020, 16'h0005, 12, 16'h0001, 14'h0003, 16'h0020, 16'h0005};
    vecs[3] = '{64'h0000_0000_0000_5040, 16'h0040, 16'h0000,  6, 16'h0000, 14'h0041, 16'h0040, 16'h0000};
    vecs[4] = '{64'h0000_0000_5040_6001, 16'h0040, 16'h0000,  9, 16'h0001, 14'h0003, 16'h0040, 16'h0000};
    vecs[5] = '{64'h0000_0000_0000_4FFF, 16'h0FFF, 16'h0000,  6, 16'h0000, 14'h1000, 16'h0FFF, 16'h0000};
    vecs[6] = '{64'h0000_0000_6055_7ABC, 16'h0030, 16'h1234,  9, 16'h0055, 14'h0003, 16'h0030, 16'h1234};
    vecs[7] = '{64'h0000_0000_3120_6009, 16'h0020, 16'h0005, 12, 16'h0004, 14'h0003, 16'h0020, 16'h0005};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_pc", pc, 14'h0000);
    chk("reset_ac", ac, 16'h0000);
    chk("reset_ir", ir, 16'h0000);
    chk("reset_halted", halted, 1'b0);
    chk("reset_illegal", illegal_op, 1'b0);
    chk("reset_mem_we", mem_we, 1'b0);
    $display("reset: pc=0x%0h ac=0x%0h ir=0x%0h halted=%0b", pc, ac, ir, halted);

    // Program table
    for (int v = 0; v < 8; v++) begin
      reset = 1'b1;
      for (int k = 0; k < 4; k++) load_word(14'(k), vecs[v].prog[16*k +: 16]);
      load_word(vecs[v].daddr[13:0], vecs[v].dval);
      launch();
      run_until_halted(cyc);
      chk($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
      chk($sformatf("vec%0d_halted", v), halted, 1'b1);
      chk($sformatf("vec%0d_ac", v), ac, vecs[v].exp_ac);
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      chk($sformatf("vec%0d_mem", v), mem[vecs[v].chk_addr[13:0]], vecs[v].exp_mem);
      $display("vec %0d: cycles=%0d ac=0x%04h pc=0x%04h mem[0x%0h]=0x%04h", v, cyc, ac, pc,
               vecs[v].chk_addr, mem[vecs[v].chk_addr[13:0]]);
    end

    // Reset asserted while the STORE is in WRITE: the write must not land
    reset = 1'b1;
    load_word(14'h0000, 16'h6ABC);
    load_word(14'h0001, 16'h2005);
    load_word(14'h0005, 16'h5555);
    launch();
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (mem_we) seen = 1'b1;
    end
    chk("wr_seen", seen, 1'b1);
    chk("wr_cycle", cyc, 6);
    reset = 1'b1;
    @(negedge clk);
    chk("wr_we_gated", mem_we, 1'b0);
    tick();
    chk("wr_mem5", mem[5], 16'h5555);
    chk("wr_pc", pc, 14'h0000);
    chk("wr_ac", ac, 16'h0000);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("wr_idle_pc", pc, 14'h0000);
    chk("wr_idle_addr", mem_addr, 16'h0000);
    chk("wr_idle_we", mem_we, 1'b0);
    $display("reset-in-write: mem[5]=0x%04h pc=0x%0h ac=0x%0h", mem[5], pc, ac);

    // PC wrap from 0x3FFF to 0x0000
    load_word(14'h3FFF, 16'h6077);
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("wrap_fetch_addr", mem_addr2, 16'h3FFF);
    tick();
    tick();
    chk("wrap_pc", pc2, 14'h0000);
    chk("wrap_ir", ir2, 16'h6077);
    tick();
    chk("wrap_ac", ac2, 16'h0077);
    reset2 = 1'b1;
    $display("wrap: pc=0x%0h ir=0x%04h ac=0x%04h", pc2, ir2, ac2);

    // JUMP 0xFFF lands exactly on 0x0FFF
    reset = 1'b1;
    load_word(14'h0000, 16'h4FFF);
    launch();
    tick();
    tick();
    tick();
    chk("jump_pc", pc, 14'h0FFF);
    chk("jump_fetch_addr", mem_addr, 16'h0FFF);
    $display("jump: pc=0x%0h mem_addr=0x%0h", pc, mem_addr);

    // Two illegal opcodes back to back: one-cycle pulses, 3 cycles apart
    reset = 1'b1;
    load_word(14'h0000, 16'h7ABC);
    load_word(14'h0001, 16'h7ABC);
    load_word(14'h0002, 16'h0000);
    launch();
    first_at = -1;
    second_at = -1;
    n_high = 0;
    pc_at_pulse = '0;
    ac_at_pulse = '0;
    cyc = 0;
    while (!halted && cyc < 20) begin
      tick();
      cyc++;
      if (illegal_op) begin
        n_high++;
        if (first_at < 0) begin
          first_at = cyc;
          pc_at_pulse = pc;
          ac_at_pulse = ac;
        end else if (second_at < 0) begin
          second_at = cyc;
        end
      end
    end
    chk("illegal_first", first_at, 2);
    chk("illegal_second", second_at, 5);
    chk("illegal_count", n_high, 2);
    chk("illegal_pc", pc_at_pulse, 14'h0001);
    chk("illegal_ac", ac_at_pulse, 16'h0000);
    $display("illegal: pulses at %0d,%0d count=%0d pc=0x%0h", first_at, second_at, n_high, pc_at_pulse);

    // HALTED resumes at the word after HALT
    reset = 1'b1;
    load_word(14'h0000, 16'h0000);
    load_word(14'h0001, 16'h6042);
    load_word(14'h0002, 16'h0000);
    launch();
    run_until_halted(cyc);
    tick();
    tick();
    tick();
    chk("halt_stay", halted, 1'b1);
    chk("halt_pc", pc, 14'h0001);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_halted", halted, 1'b0);
    chk("resume_addr", mem_addr, 16'h0001);
    run_until_halted(cyc);
    chk("resume_cycles", cyc, 6);
    chk("resume_ac", ac, 16'h0042);
    chk("resume_pc", pc, 14'h0003);
    $display("resume: cycles=%0d ac=0x%04h pc=0x%0h", cyc, ac, pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
